bsram_port_arbiter: RTL

//  Shares the single BSRAM port between three requesters:
//   - the SNES CPU (through the active cart mapper)
//   - a coprocessor engine (GSU/SA1 internal RAM fetch)
//   - the host save-file upload/download channel

---
 rtl/bsram_port_arbiter_pkg.sv | 22 ++
 rtl/bsram_port_arbiter_if.sv | 64 ++++++
 rtl/bsram_port_arbiter_pick.sv | 51 +++++
 rtl/bsram_port_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/bsram_port_arbiter_pkg.sv
// Shared types for the BSRAM port arbiter.
//   state_t  : arbiter sequencing states
//   req_id_t : requester identifiers, also used as bit positions in
//              the request / grant / acknowledge vectors
//   N_REQ    : number of requesters sharing the port
package bsram_arb_pkg;

  localparam int N_REQ = 3;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    REQ_CPU,
    REQ_COP,
    REQ_HOST
  } req_id_t;

endpackage

// File: rtl/bsram_port_arbiter_if.sv
// Bundle of every handshake and memory-pin signal around the arbiter.
//   slave  : arbiter view (takes requests and memory data, drives acks,
//            read data, busy and the BSRAM address/data/strobes)
//   master : requesters-plus-memory view (drives requests, mask and
//            bsram_q, observes everything else)
// Per requester: <r>_req, <r>_we, <r>_addr, <r>_wdata, <r>_ack
// with <r> one of cpu / cop / host.
interface bsram_port_arbiter_if #(
  parameter int AW = 20
) ();

  logic [AW-1:0] bsram_mask;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_ack;

  logic          cop_req;
  logic          cop_we;
  logic [AW-1:0] cop_addr;
  logic [7:0]    cop_wdata;
  logic          cop_ack;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic          host_ack;

  logic [7:0]    rdata;
  logic          busy;

  logic [AW-1:0] bsram_addr;
  logic [7:0]    bsram_d;
  logic [7:0]    bsram_q;
  logic          bsram_ce_n;
  logic          bsram_oe_n;
  logic          bsram_we_n;

  modport slave (
    input  bsram_mask,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cop_req, cop_we, cop_addr, cop_wdata,
    input  host_req, host_we, host_addr, host_wdata,
    input  bsram_q,
    output cpu_ack, cop_ack, host_ack,
    output rdata, busy,
    output bsram_addr, bsram_d, bsram_ce_n, bsram_oe_n, bsram_we_n
  );

  modport master (
    output bsram_mask,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cop_req, cop_we, cop_addr, cop_wdata,
    output host_req, host_we, host_addr, host_wdata,
    output bsram_q,
    input  cpu_ack, cop_ack, host_ack,
    input  rdata, busy,
    input  bsram_addr, bsram_d, bsram_ce_n, bsram_oe_n, bsram_we_n
  );

endinterface

// File: rtl/bsram_port_arbiter_pick.sv
// Combinational winner select for the BSRAM port.
//   req   : request levels, bit index = req_id_t
//   rr    : round-robin flag, 1 = COP was the last of COP/HOST served
//   grant : one-hot grant (all zero when nothing is requested)
//   win   : id of the winner (REQ_CPU when nothing is requested)
//   any   : at least one request is present
// Config macro BSRAM_ARB_RR_EN: when defined COP/HOST ties follow rr,
// otherwise COP always beats HOST and rr is ignored.
module bsram_arb_pick
  import bsram_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             rr,
  output logic [N_REQ-1:0] grant,
  output req_id_t          win,
  output logic             any
);

  logic host_wins_tie;

`ifdef BSRAM_ARB_RR_EN
  assign host_wins_tie = rr;
`else
  logic unused_rr;
  assign unused_rr     = rr;
  assign host_wins_tie = 1'b0;
`endif

  assign any = |req;

  always_comb begin
    win = REQ_CPU;
    if (req[REQ_CPU]) begin
      win = REQ_CPU;
    end else if (req[REQ_COP] && req[REQ_HOST]) begin
      win = host_wins_tie ? REQ_HOST : REQ_COP;
    end else if (req[REQ_COP]) begin
      win = REQ_COP;
    end else if (req[REQ_HOST]) begin
      win = REQ_HOST;
    end
  end

  always_comb begin
    grant = '0;
    if (any) begin
      grant[win] = 1'b1;
    end
  end

endmodule

// File: rtl/bsram_port_arbiter.sv
// Shares one BSRAM port between the SNES CPU (via mapper), a coprocessor
// engine and the host save-file channel. Each access holds ce_n low for
// MEM_LAT cycles, then pulses the winner's ack for one cycle with read
// data valid in rdata (held until the next read completes).
// Ports:
//   mclk  : master clock
//   rst_n : asynchronous active-low reset; aborts any access in flight
//   bus   : bsram_port_arbiter_if.slave (requests, acks, rdata, busy,
//           bsram_mask and the BSRAM address/data/strobe pins)
// Parameters: MEM_LAT (>=1) access length, AW address width.
// Config macro BSRAM_ARB_RR_EN: round-robin between COP and HOST.
module bsram_port_arbiter
  import bsram_arb_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int AW      = 20
) (
  input  logic                  mclk,
  input  logic                  rst_n,
  bsram_port_arbiter_if.slave   bus
);

  localparam int CW = $clog2(MEM_LAT + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             we_q;
  logic [N_REQ-1:0] owner;
  logic [N_REQ-1:0] ack_q;
  logic [AW-1:0]    addr_q;
  logic [7:0]       d_q;
  logic [7:0]       rdata_q;
  logic             ce_n_q;
  logic             oe_n_q;
  logic             we_n_q;
  logic             rr_q;

  logic [N_REQ-1:0] req_vec;
  logic [N_REQ-1:0] grant;
  req_id_t          win_id;
  logic             any_req;

  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [7:0]       sel_wdata;

  assign req_vec = {bus.host_req, bus.cop_req, bus.cpu_req};

  bsram_arb_pick u_pick (
    .req   (req_vec),
    .rr    (rr_q),
    .grant (grant),
    .win   (win_id),
    .any   (any_req)
  );

  always_comb begin
    sel_we    = bus.cpu_we;
    sel_addr  = bus.cpu_addr;
    sel_wdata = bus.cpu_wdata;
    case (win_id)
      REQ_COP: begin
        sel_we    = bus.cop_we;
        sel_addr  = bus.cop_addr;
        sel_wdata = bus.cop_wdata;
      end
      REQ_HOST: begin
        sel_we    = bus.host_we;
        sel_addr  = bus.host_addr;
        sel_wdata = bus.host_wdata;
      end
      default: ;
    endcase
  end

`ifndef BSRAM_ARB_RR_EN
  assign rr_q = 1'b0;
`endif

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      owner   <= '0;
      ack_q   <= '0;
      addr_q  <= '0;
      d_q     <= '0;
      rdata_q <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
`ifdef BSRAM_ARB_RR_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ack_q <= '0;
          if (any_req) begin
            // Strobes are registered here so they assert together with
            // the registered address and data on the first ACCESS cycle.
            owner  <= grant;
            we_q   <= sel_we;
            addr_q <= sel_addr & bus.bsram_mask;
            d_q    <= sel_wdata;
            ce_n_q <= 1'b0;
            oe_n_q <= sel_we;
            we_n_q <= ~sel_we;
            cnt    <= CW'(MEM_LAT - 1);
            state  <= ACCESS;
`ifdef BSRAM_ARB_RR_EN
            if (grant[REQ_COP]) begin
              rr_q <= 1'b1;
            end else if (grant[REQ_HOST]) begin
              rr_q <= 1'b0;
            end
`endif
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!we_q) begin
              rdata_q <= bus.bsram_q;
            end
            ce_n_q <= 1'b1;
            oe_n_q <= 1'b1;
            we_n_q <= 1'b1;
            ack_q  <= owner;
            state  <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          ack_q <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_ack    = ack_q[REQ_CPU];
  assign bus.cop_ack    = ack_q[REQ_COP];
  assign bus.host_ack   = ack_q[REQ_HOST];
  assign bus.rdata      = rdata_q;
  assign bus.busy       = (state != IDLE);
  assign bus.bsram_addr = addr_q;
  assign bus.bsram_d    = d_q;
  assign bus.bsram_ce_n = ce_n_q;
  assign bus.bsram_oe_n = oe_n_q;
  assign bus.bsram_we_n = we_n_q;

endmodule
